// File: rtl/ofdm_subcarrier_mapper.sv
// Maps 48 data symbols + 4 pilots into a 64-bin 802.11a frame in IFFT bin order; first bin 2 cycles after d47.
// Two input banks let symbol n+1 load while n drains; in_ready drops only when both banks are full.
module ofdm_subcarrier_mapper #(
  parameter int DW = 16,
  parameter logic signed [DW-1:0] PILOT_AMP = 16'sd23170
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          in_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [5:0]    out_index,
  output logic          out_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  typedef enum logic [1:0] {K_NULL, K_DATA, K_PPOS, K_PNEG} kind_t;

  localparam logic [DW-1:0] AMP_POS = PILOT_AMP;
  localparam logic [DW-1:0] AMP_NEG = -PILOT_AMP;

  logic [2*DW-1:0] mem [0:95];
  logic [1:0]      full, first_flag;
  logic            wr_bank, rd_bank;
  logic [5:0]      wr_cnt;
  logic [6:0]      lfsr, lfsr_step, lfsr_nx;
  state_t          state, state_nx;
  logic            wr_en, wr_done, hs;
  logic            load, sym_start, rd_release, ld_bank;
  logic [5:0]      ld_k, idx;
  kind_t           kind;
  logic [2*DW-1:0] rd_word;
  logic [DW-1:0]   ld_real, ld_imag;
  logic            pilot_neg;

  assign in_ready = !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign wr_done  = wr_en && (wr_cnt == 6'd47);
  assign hs       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank ? {1'b0, wr_cnt} + 7'd48 : {1'b0, wr_cnt}] <= {in_real, in_imag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      wr_cnt     <= 6'd0;
      first_flag <= 2'b00;
      full       <= 2'b00;
    end else begin
      if (wr_en) begin
        if (wr_cnt == 6'd0) first_flag[wr_bank] <= in_first;
        wr_cnt <= wr_done ? 6'd0 : wr_cnt + 6'd1;
        if (wr_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_release) full[rd_bank] <= 1'b0;
    end
  end

  // lfsr is the scrambler state for the symbol being emitted; its period of 127 is the n wrap
  assign lfsr_step = {lfsr[5:0], lfsr[6] ^ lfsr[3]};

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    sym_start  = 1'b0;
    rd_release = 1'b0;
    ld_k       = out_index + 6'd1;
    ld_bank    = rd_bank;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nx  = EMIT;
          load      = 1'b1;
          sym_start = 1'b1;
          ld_k      = 6'd0;
        end
      end
      EMIT: begin
        if (hs) begin
          if (out_last) begin
            rd_release = 1'b1;
            if (full[!rd_bank]) begin
              load      = 1'b1;
              sym_start = 1'b1;
              ld_k      = 6'd0;
              ld_bank   = !rd_bank;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    lfsr_nx = rd_release ? lfsr_step : lfsr;
    if (sym_start && first_flag[ld_bank]) lfsr_nx = 7'h7F;
  end

  // Bin k -> data slot; pilot polarity can use the registered lfsr since bin 0 is always null
  always_comb begin
    kind = K_NULL;
    idx  = 6'd0;
    if (ld_k >= 6'd1 && ld_k <= 6'd6) begin
      kind = K_DATA; idx = ld_k + 6'd23;
    end else if (ld_k == 6'd7 || ld_k == 6'd43 || ld_k == 6'd57) begin
      kind = K_PPOS;
    end else if (ld_k >= 6'd8 && ld_k <= 6'd20) begin
      kind = K_DATA; idx = ld_k + 6'd22;
    end else if (ld_k == 6'd21) begin
      kind = K_PNEG;
    end else if (ld_k >= 6'd22 && ld_k <= 6'd26) begin
      kind = K_DATA; idx = ld_k + 6'd21;
    end else if (ld_k >= 6'd38 && ld_k <= 6'd42) begin
      kind = K_DATA; idx = ld_k - 6'd38;
    end else if (ld_k >= 6'd44 && ld_k <= 6'd56) begin
      kind = K_DATA; idx = ld_k - 6'd39;
    end else if (ld_k >= 6'd58) begin
      kind = K_DATA; idx = ld_k - 6'd40;
    end
  end

  always_comb begin
    rd_word   = mem[ld_bank ? {1'b0, idx} + 7'd48 : {1'b0, idx}];
    pilot_neg = (kind == K_PNEG) ^ (lfsr[6] ^ lfsr[3]);
    ld_real   = '0;
    ld_imag   = '0;
    case (kind)
      K_DATA: begin
        ld_real = rd_word[2*DW-1:DW];
        ld_imag = rd_word[DW-1:0];
      end
      K_PPOS, K_PNEG: ld_real = pilot_neg ? AMP_NEG : AMP_POS;
      default: ld_real = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      lfsr      <= 7'h7F;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= 6'd0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      lfsr <= lfsr_nx;
      if (rd_release) rd_bank <= !rd_bank;
      if (load) begin
        out_valid <= 1'b1;
        out_index <= ld_k;
        out_last  <= (ld_k == 6'd63);
        out_real  <= ld_real;
        out_imag  <= ld_imag;
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Scoreboard bench for ofdm_subcarrier_mapper: random symbols, reference bins built from the subcarrier plan.
module tb_ofdm_subcarrier_mapper;
  localparam int AMP = 23170;
  localparam logic [15:0] PP = 16'h5A82;  // +23170
  localparam logic [15:0] PN = 16'hA57E;  // -23170

  typedef struct { logic [15:0] re; logic [15:0] im; logic first; } smp_t;
  typedef struct { logic [15:0] re; logic [15:0] im; logic [5:0] k; logic last; } bin_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, in_first, out_valid, out_ready, out_last;
  logic [15:0] in_real, in_imag, out_real, out_imag;
  logic [5:0] out_index;

  ofdm_subcarrier_mapper #(.DW(16), .PILOT_AMP(16'sd23170)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
    .out_imag(out_imag), .out_index(out_index), .out_last(out_last));

  always #5 clk = ~clk;

  smp_t stim_q[$];
  bin_t exp_q[$];
  logic [15:0] log_re[$], log_im[$];
  int log_cyc[$];
  int checks = 0, failures = 0;
  int ptab[127];
  int n_model = 0, cur_cnt = 0, n_acc = 0, cycle = 0;
  int rmode = 0, igap = 0;
  logic [15:0] cur_re[48], cur_im[48];
  logic cur_first;
  logic drv_acc, mon_stall;
  bin_t mon_h, mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_skip(input int s);
    return s == 0 || s == 7 || s == -7 || s == 21 || s == -21;
  endfunction

  // Expected bins straight from the subcarrier plan: s = k or k-64, data in ascending s order
  function automatic void emit_symbol(input int p);
    for (int k = 0; k < 64; k++) begin
      bin_t b;
      int sv, pos;
      sv = (k < 32) ? k : k - 64;
      b.re = '0; b.im = '0; b.k = 6'(k); b.last = (k == 63);
      if (sv == 0 || sv > 26 || sv < -26) begin
        b.re = '0;
      end else if (sv == 21) begin
        b.re = 16'(-p * AMP);
      end else if (sv == 7 || sv == -7 || sv == -21) begin
        b.re = 16'(p * AMP);
      end else begin
        pos = 0;
        for (int t = -26; t < sv; t++) if (!is_skip(t)) pos++;
        b.re = cur_re[pos];
        b.im = cur_im[pos];
      end
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_accept(input smp_t s);
    int pn;
    if (cur_cnt == 0) cur_first = s.first;
    cur_re[cur_cnt] = s.re;
    cur_im[cur_cnt] = s.im;
    cur_cnt++;
    if (cur_cnt == 48) begin
      pn = cur_first ? 0 : n_model;
      n_model = (pn + 1) % 127;
      emit_symbol(ptab[pn]);
      cur_cnt = 0;
    end
  endfunction

  // Input driver: samples acceptance at negedge, updates just after posedge
  initial begin
    in_valid = 1'b0; in_real = '0; in_imag = '0; in_first = 1'b0;
    forever begin
      @(negedge clk);
      drv_acc = in_valid && in_ready && !rst;
      @(posedge clk); #1;
      if (drv_acc && stim_q.size() > 0) begin
        model_accept(stim_q.pop_front());
        n_acc++;
      end
      if (stim_q.size() == 0) begin
        in_valid = 1'b0;
      end else begin
        if (!(in_valid && !drv_acc)) in_valid = (igap != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_real  = stim_q[0].re;
        in_imag  = stim_q[0].im;
        in_first = stim_q[0].first;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 9) < 7);
        2: out_ready = !(out_valid && out_index == 6'd5);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold while stalled
  initial begin
    mon_stall = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        mon_stall = 1'b0;
        continue;
      end
      if (mon_stall)
        chk("hold", {out_valid, out_real, out_imag, out_index, out_last},
            {1'b1, mon_h.re, mon_h.im, mon_h.k, mon_h.last});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bin", {1'b1, out_index}, 7'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bin", {out_real, out_imag, out_index, out_last}, {mon_e.re, mon_e.im, mon_e.k, mon_e.last});
        end
        log_re.push_back(out_real);
        log_im.push_back(out_imag);
        log_cyc.push_back(cycle);
      end
      mon_stall = out_valid && !out_ready;
      mon_h.re = out_real; mon_h.im = out_imag; mon_h.k = out_index; mon_h.last = out_last;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stim_q.delete(); exp_q.delete();
    n_model = 0; cur_cnt = 0; n_acc = 0;
    cyc(1);
    chk("reset_outputs", {out_valid, out_last, out_index, out_real, out_imag}, 39'd0);
    log_re.delete(); log_im.delete(); log_cyc.delete();
    rst = 1'b0;
    cyc(1);
    chk("reset_in_ready", in_ready, 1);
  endtask

  task automatic push_sym(input bit ramp, input bit f0, input bit f5);
    for (int i = 0; i < 48; i++) begin
      smp_t s;
      if (ramp) begin
        s.re = 16'(i + 1); s.im = 16'(-(i + 1));
      end else begin
        s.re = 16'($urandom); s.im = 16'($urandom);
      end
      s.first = (i == 0 && f0) || (i == 5 && f5);
      stim_q.push_back(s);
    end
  endtask

  task automatic wait_drain(input int limit, input string name);
    int c = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || cur_cnt != 0) && c < limit) begin
      cyc(1);
      c++;
    end
    chk(name, exp_q.size() + stim_q.size(), 0);
    cyc(2);
  endtask

  initial begin
    int c;
    logic [7:1] x;
    logic b;
    x = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      b = x[7] ^ x[4];
      ptab[i] = b ? -1 : 1;
      x = {x[6:1], b};
    end
    cyc(2);

    // Single symbol, ramp data, first-bin latency
    do_reset();
    push_sym(1'b1, 1'b0, 1'b0);
    c = 0;
    while (n_acc < 48 && c < 200) begin cyc(1); c++; end
    chk("lat_t1_valid", out_valid, 0);
    cyc(1);
    chk("lat_t2_valid_k0", {out_valid, out_index}, {1'b1, 6'd0});
    wait_drain(500, "single_drain");
    chk("single_count", log_re.size(), 64);
    chk("single_k0", {log_re[0], log_im[0]}, 32'd0);
    chk("single_k1", {log_re[1], log_im[1]}, {16'd25, 16'hFFE7});
    chk("single_k7", {log_re[7], log_im[7]}, {PP, 16'd0});
    chk("single_k21", {log_re[21], log_im[21]}, {PN, 16'd0});
    chk("single_k30", {log_re[30], log_im[30]}, 32'd0);
    chk("single_k38", {log_re[38], log_im[38]}, {16'd1, 16'hFFFF});
    chk("single_k43", log_re[43], PP);
    chk("single_k63", {log_re[63], log_im[63]}, {16'd24, 16'hFFE8});

    // Polarity across the 127-symbol wrap, back-to-back
    do_reset();
    for (int s = 0; s < 130; s++) push_sym(1'b0, 1'b0, 1'b0);
    wait_drain(30000, "polarity_drain");
    chk("polarity_count", log_re.size(), 130 * 64);
    if (log_re.size() == 130 * 64) begin
      chk("pol_sym0_k7", log_re[7], PP);
      chk("pol_sym4_k7", log_re[4 * 64 + 7], PN);
      chk("pol_sym4_k21", log_re[4 * 64 + 21], PP);
      chk("pol_sym127_k7", log_re[127 * 64 + 7], PP);
      chk("pol_sym127_k21", log_re[127 * 64 + 21], PN);
      chk("gap_free", log_cyc[130 * 64 - 1] - log_cyc[0], 130 * 64 - 1);
    end

    // in_first on d0 of symbol 10 restarts polarity; on d5 of symbol 5 it is ignored
    do_reset();
    for (int s = 0; s < 15; s++) push_sym(1'b0, s == 10, s == 5);
    wait_drain(3000, "first_drain");
    chk("first_count", log_re.size(), 15 * 64);
    if (log_re.size() == 15 * 64) begin
      chk("first_sym5_k7", log_re[5 * 64 + 7], PN);
      chk("first_sym10_k7", log_re[10 * 64 + 7], PP);
      chk("first_sym11_k7", log_re[11 * 64 + 7], PP);
      chk("first_sym14_k7", log_re[14 * 64 + 7], PN);
    end

    // Backpressure: stall at k=5 while two more symbols arrive
    do_reset();
    rmode = 2;
    push_sym(1'b0, 1'b0, 1'b0);
    c = 0;
    while (!(out_valid && out_index == 6'd5 && !out_ready) && c < 300) begin cyc(1); c++; end
    push_sym(1'b0, 1'b0, 1'b0);
    push_sym(1'b0, 1'b0, 1'b0);
    cyc(200);
    chk("bp_hold_k5", {out_valid, out_index}, {1'b1, 6'd5});
    chk("bp_stored", n_acc, 96);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_emitted", log_re.size(), 5);
    rmode = 0;
    c = 0;
    while (!(out_valid && out_ready && out_last) && c < 300) begin cyc(1); c++; end
    cyc(1);
    chk("bp_in_ready_after_last", in_ready, 1);
    wait_drain(1000, "bp_drain");
    chk("bp_count", log_re.size(), 192);

    // Random stalls on both sides
    do_reset();
    rmode = 1; igap = 1;
    for (int s = 0; s < 200; s++) push_sym(1'b0, 1'b0, $urandom_range(0, 7) == 0);
    wait_drain(60000, "random_drain");
    chk("random_count", log_re.size(), 200 * 64);
    rmode = 0; igap = 0;

    // Reset during k=30 of symbol 5 with 20 samples of the next symbol stored
    do_reset();
    for (int s = 0; s < 6; s++) push_sym(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) stim_q.push_back('{16'($urandom), 16'($urandom), 1'b0});
    c = 0;
    while (!(log_re.size() >= 5 * 64 + 30 && n_acc >= 6 * 48 + 20) && c < 2000) begin cyc(1); c++; end
    chk("rst_mid_at_k30", {out_valid, out_index}, {1'b1, 6'd30});
    do_reset();
    push_sym(1'b1, 1'b0, 1'b0);
    wait_drain(500, "post_rst_drain");
    chk("post_rst_count", log_re.size(), 64);
    if (log_re.size() == 64) begin
      chk("post_rst_k1", {log_re[1], log_im[1]}, {16'd25, 16'hFFE7});
      chk("post_rst_k7", log_re[7], PP);
      chk("post_rst_k21", log_re[21], PN);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
